pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter: CNT_W, 32, width of the performance counters.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 D_icode, E_icode, M_icode, W_icode  input  4 each  stage instruction codes (0 HALT, 1 NOP, 5 MRMOVQ, 6 OPQ, 7 JXX, 9 RET, B POPQ).
REQ-005 d_srcA, d_srcB  input  4 each  decode source registers; 4'hF = RNONE.
REQ-006 E_dstM  input  4  memory-load destination in E.
REQ-007 e_Cnd  input  1  branch condition computed in E.
REQ-008 m_stat, W_stat  input  2 each  status (0 AOK, 1 HLT, 2 ADR, 3 INS).
REQ-009 F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall  output  1 each  pipeline-register controls.
REQ-010 set_cc  output  1  enable condition-code update.
REQ-011 cpu_stat  output  2  registered architectural status.
REQ-012 halted  output  1  high when the controller is in HALT or FAULT.
REQ-013 cyc_cnt, ret_cnt, lu_cnt, mp_cnt  output  CNT_W each  cycle, retired, load-use, mispredict counts.

Function
REQ-014 lu: E_icode in {MRMOVQ, POPQ}, E_dstM != RNONE, and E_dstM equals d_srcA or d_srcB.
REQ-015 rp: RET in any of D_icode, E_icode, M_icode.
REQ-016 mp: E_icode = JXX and e_Cnd = 0.
REQ-017 exc: m_stat != AOK or W_stat != AOK.
REQ-018 In RUN, controls are combinational with zero latency:
- F_stall = lu | rp
- D_stall = lu
- D_bubble = mp | (rp & ~lu)
- E_bubble = mp | lu
- M_bubble = m_stat != AOK | W_stat != AOK
- W_stall = W_stat != AOK
- set_cc = E_icode = OPQ & ~exc
REQ-019 D_stall and D_bubble are never both high; on a conflict, D_stall wins.
REQ-020 The FSM has states RUN, HALT and FAULT.
- RUN to HALT: at the posedge where W_stat = HLT.
- RUN to FAULT: at the posedge where W_stat is ADR or INS.
- HALT and FAULT are sticky until reset.
REQ-021 In HALT or FAULT: F_stall = 1, D_stall = 1, W_stall = 1, E_bubble = 1, M_bubble = 1, D_bubble = 0, set_cc = 0, halted = 1.
REQ-022 cpu_stat updates on each posedge in RUN:
- equals W_stat when W_stat != AOK, else AOK.
- holds its value in HALT or FAULT.
REQ-023 cyc_cnt increments every posedge in RUN and freezes in HALT or FAULT.
REQ-024 ret_cnt increments when in RUN, W_stat = AOK and W_icode is not NOP (bubbles are not counted).
REQ-025 lu_cnt increments in RUN on each cycle lu is high; mp_cnt increments in RUN on each cycle mp is high.
REQ-026 All counters wrap modulo 2^CNT_W with no saturation.
REQ-027 If lu, mp and rp are all high together, each REQ-018 equation applies independently; only REQ-019 arbitrates.

Reset
REQ-028 While rst_n = 0, outputs take these values asynchronously:
- F_stall = 1, D_bubble = 1, E_bubble = 1, M_bubble = 1
- D_stall = 0, W_stall = 0, set_cc = 0, halted = 0
REQ-029 Reset clears the FSM to RUN, cpu_stat to AOK and all counters to 0, including a reset asserted mid-HALT or mid-stall.
REQ-030 The first posedge after rst_n rises evaluates REQ-018 normally.

Configuration
REQ-031 Macro PIPE_CTRL_PERF_EN.
- Defined: the counters are implemented per REQ-023 to REQ-026.
- Undefined: no counter flops exist, and cyc_cnt, ret_cnt, lu_cnt and mp_cnt are tied to 0.
- Control outputs, FSM and cpu_stat are identical in both builds.

Verification
REQ-032 E_icode = 5, E_dstM = 3, d_srcA = 3 -> F_stall = 1, D_stall = 1, E_bubble = 1, D_bubble = 0; lu_cnt +1 per cycle held.
REQ-033 E_icode = 7, e_Cnd = 0, D_icode = 9 -> D_bubble = 1, E_bubble = 1, F_stall = 1; mp_cnt +1.
REQ-034 M_icode = 9, no lu -> F_stall = 1, D_bubble = 1; three consecutive RET-in-pipe cycles each assert both.
REQ-035 W_stat = 1 at posedge N -> from N onward halted = 1, cpu_stat = 1, all stalls per REQ-021, cyc_cnt frozen; later W_stat = 0 leaves the state unchanged.
REQ-036 Drive m_stat = 2 with E_icode = 6 -> set_cc = 0, M_bubble = 1; next W_stat = 2 -> FAULT, cpu_stat = 2; pulse rst_n low mid-FAULT -> RUN, counters = 0.
REQ-037 With the macro defined, preload cyc_cnt to 2^CNT_W - 1 by running -> next cycle reads 0; with the macro undefined, all counters read 0 throughout.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- hazard and status controller for a five-stage Y86-style pipeline.
//
// Build option: define PIPE_CTRL_PERF_EN to implement the performance
// counters. Without it, no counter flops exist and the count outputs read 0.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   D_icode/E_icode/M_icode/W_icode stage instruction codes
//   d_srcA, d_srcB                  decode source registers (4'hF = none)
//   E_dstM                          load destination held in E
//   e_Cnd                           branch condition computed in E
//   m_stat, W_stat                  memory / write-back stage status
//   F_stall..W_stall                pipeline register controls
//   set_cc                          condition-code update enable
//   cpu_stat                        registered architectural status
//   halted                          controller is in HALT or FAULT
//   cyc_cnt/ret_cnt/lu_cnt/mp_cnt   cycle, retired, load-use, mispredict counts
//
// state | meaning
// RUN   | normal operation, hazard controls computed from stage contents
// HALT  | HLT reached write-back; pipeline frozen until reset
// FAULT | ADR or INS reached write-back; pipeline frozen until reset

module pipe_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       M_icode,
    input  logic [3:0]       W_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [1:0]       m_stat,
    input  logic [1:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             set_cc,
    output logic [1:0]       cpu_stat,
    output logic             halted,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] mp_cnt
);

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] R_NONE   = 4'hF;

    localparam logic [1:0] ST_AOK = 2'd0;
    localparam logic [1:0] ST_HLT = 2'd1;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_HALT  = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_cpu_stat;

    logic w_lu;
    logic w_rp;
    logic w_mp;
    logic w_exc;
    logic w_run;

    assign w_lu  = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
                   (E_dstM != R_NONE) &&
                   ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign w_rp  = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    assign w_mp  = (E_icode == I_JXX) && !e_Cnd;
    assign w_exc = (m_stat != ST_AOK) || (W_stat != ST_AOK);
    assign w_run = (r_state == S_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_RUN;
            r_cpu_stat <= ST_AOK;
        end else begin
            r_state <= w_state_nxt;
            if (w_run) begin
                r_cpu_stat <= W_stat;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        F_stall     = 1'b0;
        D_stall     = 1'b0;
        D_bubble    = 1'b0;
        E_bubble    = 1'b0;
        M_bubble    = 1'b0;
        W_stall     = 1'b0;
        set_cc      = 1'b0;
        halted      = 1'b0;

        case (r_state)
            S_RUN: begin
                if (W_stat == ST_HLT) begin
                    w_state_nxt = S_HALT;
                end else if (W_stat != ST_AOK) begin
                    w_state_nxt = S_FAULT;
                end
                F_stall  = w_lu | w_rp;
                D_stall  = w_lu;
                // A stalled decode register must not also be bubbled.
                D_bubble = (w_mp | (w_rp & ~w_lu)) & ~w_lu;
                E_bubble = w_mp | w_lu;
                M_bubble = w_exc;
                W_stall  = (W_stat != ST_AOK);
                set_cc   = (E_icode == I_OPQ) & ~w_exc;
            end
            default: begin
                F_stall  = 1'b1;
                D_stall  = 1'b1;
                E_bubble = 1'b1;
                M_bubble = 1'b1;
                W_stall  = 1'b1;
                halted   = 1'b1;
            end
        endcase

        // Reset forces a flushing pattern without waiting for a clock.
        if (!rst_n) begin
            F_stall  = 1'b1;
            D_bubble = 1'b1;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
            D_stall  = 1'b0;
            W_stall  = 1'b0;
            set_cc   = 1'b0;
            halted   = 1'b0;
        end
    end

    assign cpu_stat = r_cpu_stat;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] r_cyc_cnt;
    logic [CNT_W-1:0] r_ret_cnt;
    logic [CNT_W-1:0] r_lu_cnt;
    logic [CNT_W-1:0] r_mp_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cyc_cnt <= '0;
            r_ret_cnt <= '0;
            r_lu_cnt  <= '0;
            r_mp_cnt  <= '0;
        end else if (w_run) begin
            r_cyc_cnt <= r_cyc_cnt + CNT_W'(1);
            // Bubbles travel as NOPs and are not retirements.
            if ((W_stat == ST_AOK) && (W_icode != I_NOP)) begin
                r_ret_cnt <= r_ret_cnt + CNT_W'(1);
            end
            if (w_lu) begin
                r_lu_cnt <= r_lu_cnt + CNT_W'(1);
            end
            if (w_mp) begin
                r_mp_cnt <= r_mp_cnt + CNT_W'(1);
            end
        end
    end

    assign cyc_cnt = r_cyc_cnt;
    assign ret_cnt = r_ret_cnt;
    assign lu_cnt  = r_lu_cnt;
    assign mp_cnt  = r_mp_cnt;
`else
    logic w_unused;
    assign w_unused = ^W_icode;

    assign cyc_cnt = '0;
    assign ret_cnt = '0;
    assign lu_cnt  = '0;
    assign mp_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl -- bench for pipe_ctrl with a narrow counter width so that
// counter wrap-around is reachable in a few cycles.

module tb_pipe_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    D_icode, E_icode, M_icode, W_icode;
    logic [3:0]    d_srcA, d_srcB, E_dstM;
    logic          e_Cnd;
    logic [1:0]    m_stat, W_stat;
    logic          F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall;
    logic          set_cc, halted;
    logic [1:0]    cpu_stat;
    logic [CW-1:0] cyc_cnt, ret_cnt, lu_cnt, mp_cnt;

    int checks = 0;
    int errors = 0;

    pipe_ctrl #(.CNT_W(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .D_icode  (D_icode),
        .E_icode  (E_icode),
        .M_icode  (M_icode),
        .W_icode  (W_icode),
        .d_srcA   (d_srcA),
        .d_srcB   (d_srcB),
        .E_dstM   (E_dstM),
        .e_Cnd    (e_Cnd),
        .m_stat   (m_stat),
        .W_stat   (W_stat),
        .F_stall  (F_stall),
        .D_stall  (D_stall),
        .D_bubble (D_bubble),
        .E_bubble (E_bubble),
        .M_bubble (M_bubble),
        .W_stall  (W_stall),
        .set_cc   (set_cc),
        .cpu_stat (cpu_stat),
        .halted   (halted),
        .cyc_cnt  (cyc_cnt),
        .ret_cnt  (ret_cnt),
        .lu_cnt   (lu_cnt),
        .mp_cnt   (mp_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit stopped = 1'b0;      // controller has seen a non-AOK write-back
    int m_stat_q = 0;
    int m_cyc = 0, m_ret = 0, m_lu = 0, m_mp = 0;

    function automatic bit f_lu();
        return (E_icode == 4'h5 || E_icode == 4'hB) && E_dstM != 4'hF &&
               (E_dstM == d_srcA || E_dstM == d_srcB);
    endfunction
    function automatic bit f_rp();
        return D_icode == 4'h9 || E_icode == 4'h9 || M_icode == 4'h9;
    endfunction
    function automatic bit f_mp();
        return E_icode == 4'h7 && e_Cnd == 1'b0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stopped  <= 1'b0;
            m_stat_q <= 0;
            m_cyc <= 0; m_ret <= 0; m_lu <= 0; m_mp <= 0;
        end else if (!stopped) begin
            m_cyc <= m_cyc + 1;
            if (W_stat == 2'd0 && W_icode != 4'h1) m_ret <= m_ret + 1;
            if (f_lu()) m_lu <= m_lu + 1;
            if (f_mp()) m_mp <= m_mp + 1;
            m_stat_q <= int'(W_stat);
            if (W_stat != 2'd0) stopped <= 1'b1;
        end
    end

    function automatic logic [31:0] cnt_exp(input int v);
`ifdef PIPE_CTRL_PERF_EN
        return 32'(v % (1 << CW));
`else
        return 32'(v - v);
`endif
    endfunction

    always @(negedge clk) begin
        bit lu, rp, mp, exc;
        bit ef, eds, edb, eeb, emb, ews, ecc, eh;
        lu  = f_lu();
        rp  = f_rp();
        mp  = f_mp();
        exc = (m_stat != 0) || (W_stat != 0);
        if (!rst_n) begin
            ef = 1; edb = 1; eeb = 1; emb = 1; eds = 0; ews = 0; ecc = 0; eh = 0;
        end else if (stopped) begin
            ef = 1; eds = 1; ews = 1; eeb = 1; emb = 1; edb = 0; ecc = 0; eh = 1;
        end else begin
            ef  = lu || rp;
            eds = lu;
            edb = (mp || (rp && !lu)) && !eds;
            eeb = mp || lu;
            emb = exc;
            ews = (W_stat != 0);
            ecc = (E_icode == 4'h6) && !exc;
            eh  = 0;
        end
        chk("F_stall",  32'(F_stall),  32'(ef));
        chk("D_stall",  32'(D_stall),  32'(eds));
        chk("D_bubble", 32'(D_bubble), 32'(edb));
        chk("E_bubble", 32'(E_bubble), 32'(eeb));
        chk("M_bubble", 32'(M_bubble), 32'(emb));
        chk("W_stall",  32'(W_stall),  32'(ews));
        chk("set_cc",   32'(set_cc),   32'(ecc));
        chk("halted",   32'(halted),   32'(eh));
        chk("cpu_stat", 32'(cpu_stat), 32'(m_stat_q));
        chk("cyc_cnt",  32'(cyc_cnt),  cnt_exp(m_cyc));
        chk("ret_cnt",  32'(ret_cnt),  cnt_exp(m_ret));
        chk("lu_cnt",   32'(lu_cnt),   cnt_exp(m_lu));
        chk("mp_cnt",   32'(mp_cnt),   cnt_exp(m_mp));
    end

    // ---------------- directed stimulus ----------------
    task automatic nop_in();
        D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1; W_icode = 4'h1;
        d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF;
        e_Cnd = 1'b1; m_stat = 2'd0; W_stat = 2'd0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        nop_in();
        step(2);
        #2;
        chk("rst F_stall",  32'(F_stall),  32'd1);
        chk("rst D_bubble", 32'(D_bubble), 32'd1);
        chk("rst D_stall",  32'(D_stall),  32'd0);
        chk("rst halted",   32'(halted),   32'd0);
        chk("rst cpu_stat", 32'(cpu_stat), 32'd0);
        rst_n = 1'b1;

        // counter wrap: 15 posedges reach the top, the 16th returns to 0
        step(15);
`ifdef PIPE_CTRL_PERF_EN
        chk("cyc top",  32'(cyc_cnt), 32'hF);
`else
        chk("cyc tied", 32'(cyc_cnt), 32'h0);
`endif
        step(1);
        chk("cyc wrap", 32'(cyc_cnt), 32'h0);

        // load-use held for three cycles
        E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
        #2;
        chk("lu F_stall",  32'(F_stall),  32'd1);
        chk("lu D_stall",  32'(D_stall),  32'd1);
        chk("lu E_bubble", 32'(E_bubble), 32'd1);
        chk("lu D_bubble", 32'(D_bubble), 32'd0);
        step(3);
`ifdef PIPE_CTRL_PERF_EN
        chk("lu_cnt 3", 32'(lu_cnt), 32'd3);
`else
        chk("lu_cnt 0", 32'(lu_cnt), 32'd0);
`endif
        // load-use together with RET in decode: stall wins over bubble
        D_icode = 4'h9; E_icode = 4'hB; d_srcA = 4'h0; d_srcB = 4'h3;
        #2;
        chk("lu+rp D_stall",  32'(D_stall),  32'd1);
        chk("lu+rp D_bubble", 32'(D_bubble), 32'd0);
        step(1);

        // mispredict with RET in decode
        nop_in();
        E_icode = 4'h7; e_Cnd = 1'b0; D_icode = 4'h9;
        #2;
        chk("mp D_bubble", 32'(D_bubble), 32'd1);
        chk("mp E_bubble", 32'(E_bubble), 32'd1);
        chk("mp F_stall",  32'(F_stall),  32'd1);
        chk("mp D_stall",  32'(D_stall),  32'd0);
        step(1);

        // RET in memory for three cycles, with retiring instructions
        nop_in();
        M_icode = 4'h9; W_icode = 4'h6;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("rp F_stall",  32'(F_stall),  32'd1);
            chk("rp D_bubble", 32'(D_bubble), 32'd1);
            step(1);
        end

        // OPQ sets CC normally, not with a memory exception
        nop_in();
        E_icode = 4'h6;
        #2;
        chk("opq set_cc", 32'(set_cc), 32'd1);
        step(1);
        m_stat = 2'd2;
        #2;
        chk("exc set_cc",   32'(set_cc),   32'd0);
        chk("exc M_bubble", 32'(M_bubble), 32'd1);
        step(1);
        m_stat = 2'd0; W_stat = 2'd2;
        step(1);
        W_stat = 2'd0;
        #2;
        chk("fault halted",   32'(halted),   32'd1);
        chk("fault cpu_stat", 32'(cpu_stat), 32'd2);
        step(2);

        // reset pulse mid-fault
        rst_n = 1'b0;
        #2;
        chk("rst mid halted", 32'(halted),   32'd0);
        chk("rst mid cyc",    32'(cyc_cnt),  32'd0);
        chk("rst mid stat",   32'(cpu_stat), 32'd0);
        step(1);
        rst_n = 1'b1;
        step(2);

        // HLT reaches write-back; state sticks after W_stat returns to AOK
        W_icode = 4'h0; W_stat = 2'd1;
        #2;
        chk("pre-halt W_stall", 32'(W_stall), 32'd1);
        step(1);
        W_stat = 2'd0; E_icode = 4'h6;
        #2;
        chk("halt halted",   32'(halted),   32'd1);
        chk("halt cpu_stat", 32'(cpu_stat), 32'd1);
        chk("halt set_cc",   32'(set_cc),   32'd0);
        step(4);
        chk("halt sticky", 32'(halted), 32'd1);

        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        nop_in();
        step(2);
        chk("post halted", 32'(halted), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
